// File: rtl/jk_machine_sequencer.sv
// Round-robin sequencer that shares one 3-bit JK machine between two requesters,
// streams a pattern into x, and returns the F trace and final state.
module jk_machine_sequencer #(
  parameter int W  = 8,
  parameter int LW = $clog2(W) + 1
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          req0,
  input  logic          req1,
  input  logic [W-1:0]  pat0,
  input  logic [W-1:0]  pat1,
  input  logic [LW-1:0] len0,
  input  logic [LW-1:0] len1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          m_x,
  output logic          m_reset,
  input  logic          m_f,
  input  logic [2:0]    m_s,
  output logic          busy,
  output logic          done,
  output logic          done_id,
  output logic          err,
  output logic [W-1:0]  f_trace,
  output logic [2:0]    final_s
);

  localparam int IW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [2:0] {IDLE, CLR, RUN, CAP, DONE} state_t;

  state_t        state_q, state_d;
  logic          last_id_q, last_id_d;
  logic [W-1:0]  pat_q, pat_d;
  logic [LW-1:0] len_q, len_d;
  logic [IW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  f_trace_q, f_trace_d;
  logic [2:0]    final_s_q, final_s_d;
  logic          done_id_q, done_id_d;
  logic          gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic          done_q, done_d, err_q, err_d;
  logic          m_x_q, m_x_d, m_clr_q, m_clr_d;
  logic          busy_q, busy_d;
  logic          win_id;

  function automatic logic [LW-1:0] clamp_len(input logic [LW-1:0] l);
    return (l > LW'(W)) ? LW'(W) : l;
  endfunction

  always_comb begin
    state_d   = state_q;
    last_id_d = last_id_q;
    pat_d     = pat_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    f_trace_d = f_trace_q;
    final_s_d = final_s_q;
    done_id_d = done_id_q;
    gnt0_d    = 1'b0;
    gnt1_d    = 1'b0;
    done_d    = 1'b0;
    err_d     = 1'b0;
    m_x_d     = 1'b0;
    m_clr_d   = 1'b0;
    win_id    = (req0 && req1) ? ~last_id_q : req1;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          last_id_d = win_id;
          done_id_d = win_id;
          pat_d     = win_id ? pat1 : pat0;
          len_d     = clamp_len(win_id ? len1 : len0);
          cnt_d     = '0;
          f_trace_d = '0;
          final_s_d = '0;
          gnt0_d    = ~win_id;
          gnt1_d    = win_id;
          // A zero-length run is rejected straight to DONE without touching the machine.
          if (len_d == '0) begin
            state_d = DONE;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end else begin
            state_d = CLR;
            m_clr_d = 1'b1;
          end
        end
      end
      CLR: begin
        state_d   = RUN;
        cnt_d     = '0;
        f_trace_d = '0;
        m_x_d     = pat_q[0];
      end
      RUN: begin
        f_trace_d[cnt_q] = m_f;
        if (LW'(cnt_q) == len_q - LW'(1)) begin
          state_d = CAP;
        end else begin
          cnt_d = cnt_q + IW'(1);
          m_x_d = pat_q[cnt_d];
        end
      end
      CAP: begin
        final_s_d = m_s;
        state_d   = DONE;
        done_d    = 1'b1;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= IDLE;
      last_id_q <= 1'b1;
      f_trace_q <= '0;
      final_s_q <= '0;
      done_id_q <= 1'b0;
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      m_x_q     <= 1'b0;
      m_clr_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_id_q <= last_id_d;
      f_trace_q <= f_trace_d;
      final_s_q <= final_s_d;
      done_id_q <= done_id_d;
      gnt0_q    <= gnt0_d;
      gnt1_q    <= gnt1_d;
      done_q    <= done_d;
      err_q     <= err_d;
      m_x_q     <= m_x_d;
      m_clr_q   <= m_clr_d;
      busy_q    <= busy_d;
    end
    pat_q <= pat_d;
    len_q <= len_d;
    cnt_q <= cnt_d;
  end

  assign gnt0    = gnt0_q;
  assign gnt1    = gnt1_q;
  assign m_x     = m_x_q;
  assign m_reset = m_clr_q | RESET;
  assign busy    = busy_q;
  assign done    = done_q;
  assign done_id = done_id_q;
  assign err     = err_q;
  assign f_trace = f_trace_q;
  assign final_s = final_s_q;

endmodule

// File: tb/tb_jk_machine_sequencer.sv
// Directed bench for jk_machine_sequencer with a counting JK machine stub.
module tb_jk_machine_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, req1;
  logic [7:0] pat0, pat1;
  logic [3:0] len0, len1;
  logic       gnt0, gnt1, m_x, m_reset, m_f;
  logic [2:0] m_s;
  logic       busy, done, done_id, err;
  logic [7:0] f_trace;
  logic [2:0] final_s;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // Machine stub: S clears on m_reset, otherwise counts mod 8; F = S[0].
  logic [2:0] s_q;
  always_ff @(posedge clk) s_q <= m_reset ? 3'd0 : s_q + 3'd1;
  assign m_s = s_q;
  assign m_f = s_q[0];

  jk_machine_sequencer #(.W(8)) dut (
    .CLK(clk), .RESET(rst),
    .req0(req0), .req1(req1), .pat0(pat0), .pat1(pat1), .len0(len0), .len1(len1),
    .gnt0(gnt0), .gnt1(gnt1), .m_x(m_x), .m_reset(m_reset), .m_f(m_f), .m_s(m_s),
    .busy(busy), .done(done), .done_id(done_id), .err(err),
    .f_trace(f_trace), .final_s(final_s)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       r0, r1;
    logic [7:0] p0, p1;
    logic [3:0] l0, l1;
    logic       eg0, eg1, eid, eerr;
    logic [7:0] eft;
    logic [2:0] efs;
    int         elat;
    logic [7:0] ex;
    int         emr;
  } vec_t;

  vec_t tv[6];

  task automatic run_vec(input vec_t v, input int idx);
    int cyc;
    bit seen;
    logic [7:0] xs;
    int mr;
    string nm;
    nm = $sformatf("vec%0d", idx);
    req0 = v.r0; req1 = v.r1; pat0 = v.p0; pat1 = v.p1; len0 = v.l0; len1 = v.l1;
    cyc = 0; seen = 0; xs = '0; mr = 0;
    while (!seen && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 1) begin
        chk({nm, " gnt0"}, int'(gnt0), int'(v.eg0));
        chk({nm, " gnt1"}, int'(gnt1), int'(v.eg1));
      end
      if (m_reset) mr++;
      if (cyc >= 2 && cyc <= v.elat - 2 && cyc - 2 < 8) xs[cyc-2] = m_x;
      if (done) seen = 1;
    end
    chk({nm, " latency"}, seen ? cyc : -1, v.elat);
    chk({nm, " done_id"}, int'(done_id), int'(v.eid));
    chk({nm, " err"}, int'(err), int'(v.eerr));
    chk({nm, " f_trace"}, int'(f_trace), int'(v.eft));
    chk({nm, " final_s"}, int'(final_s), int'(v.efs));
    chk({nm, " m_x seq"}, int'(xs), int'(v.ex));
    chk({nm, " m_reset pulses"}, mr, v.emr);
    req0 = 1'b0; req1 = 1'b0;
    @(posedge clk); #1;
    chk({nm, " done one-shot"}, int'(done), 0);
  endtask

  initial begin
    int ng;
    int ids[4];
    int cyc;
    //            r0    r1    p0     p1     l0     l1    eg0   eg1   eid   eerr  eft    efs   lat x      mr
    tv[0] = '{1'b1, 1'b0, 8'h00, 8'h00, 4'd5,  4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h0A, 3'd5, 8,  8'h00, 1};
    tv[1] = '{1'b0, 1'b1, 8'h00, 8'hB5, 4'd0,  4'd8, 1'b0, 1'b1, 1'b1, 1'b0, 8'hAA, 3'd0, 11, 8'hB5, 1};
    tv[2] = '{1'b1, 1'b0, 8'hFF, 8'h00, 4'd0,  4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 3'd0, 1,  8'h00, 0};
    tv[3] = '{1'b1, 1'b0, 8'h3C, 8'h00, 4'd12, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'hAA, 3'd0, 11, 8'h3C, 1};
    tv[4] = '{1'b0, 1'b1, 8'h00, 8'hFF, 4'd0,  4'd1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 3'd1, 4,  8'h01, 1};
    tv[5] = '{1'b0, 1'b1, 8'h00, 8'h06, 4'd0,  4'd3, 1'b0, 1'b1, 1'b1, 1'b0, 8'h02, 3'd3, 6,  8'h06, 1};

    rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
    pat0 = '0; pat1 = '0; len0 = '0; len1 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset m_reset", int'(m_reset), 1);
    chk("reset busy", int'(busy), 0);
    chk("reset done", int'(done), 0);
    chk("reset gnt", int'({gnt1, gnt0}), 0);
    chk("reset m_x", int'(m_x), 0);
    chk("reset err", int'(err), 0);
    chk("reset f_trace", int'(f_trace), 0);
    chk("reset final_s", int'(final_s), 0);
    chk("reset done_id", int'(done_id), 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle m_reset", int'(m_reset), 0);

    // Tie after reset: req0 first, then strict alternation.
    req0 = 1'b1; req1 = 1'b1; len0 = 4'd2; len1 = 4'd2;
    ng = 0; cyc = 0;
    while (ng < 4 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      if (gnt0 || gnt1) begin
        ids[ng] = gnt1 ? 1 : 0;
        chk("tie single grant", int'(gnt0 & gnt1), 0);
        ng++;
      end
    end
    chk("tie grant count", ng, 4);
    for (int i = 0; i < 4; i++) chk($sformatf("tie grant%0d id", i), (i < ng) ? ids[i] : -1, i % 2);
    req0 = 1'b0; req1 = 1'b0;
    cyc = 0;
    while (busy && cyc < 20) begin @(posedge clk); #1; cyc++; end
    chk("tie drain idle", int'(busy), 0);

    // Reset during RUN step 3 of a len=6 run, with req0 held throughout.
    req0 = 1'b1; len0 = 4'd6; pat0 = 8'h00;
    repeat (5) @(posedge clk);
    #1;
    chk("midrun busy before reset", int'(busy), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrun reset busy", int'(busy), 0);
    chk("midrun reset f_trace", int'(f_trace), 0);
    chk("midrun reset done", int'(done), 0);
    chk("midrun reset gnt0", int'(gnt0), 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("restart gnt0", int'(gnt0), 1);
    chk("restart m_reset", int'(m_reset), 1);
    cyc = 0;
    while (!done && cyc < 30) begin @(posedge clk); #1; cyc++; end
    chk("restart latency", done ? cyc : -1, 8);
    chk("restart f_trace", int'(f_trace), 8'h2A);
    chk("restart final_s", int'(final_s), 6);
    req0 = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) run_vec(tv[i], i);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/jk_machine_sequencer.md
# jk_machine_sequencer

Controller that owns the 3-bit JK state machine (x/F/S datapath) and shares it between two requesters. A requester supplies an input pattern and a length. The sequencer grants the machine round-robin, clears it, streams the pattern into `x` one bit per clock, records `F` on every step, and returns the F trace and the final state with a done pulse. It sits between the stimulus/config logic and the machine instance.

## Interface
- `W`, default 8: maximum pattern length in bits; `LW = $clog2(W)+1`.
- `CLK`  in  1  single system clock, rising edge.
- `RESET`  in  1  synchronous, active-high reset of the sequencer.
- `req0`, `req1`  in  1  request; held high by the requester, with `pat`/`len` stable, until its `done`.
- `pat0`, `pat1`  in  W  x pattern, applied LSB first.
- `len0`, `len1`  in  LW  number of steps; 0 is illegal; values above W clamp to W.
- `gnt0`, `gnt1`  out  1  one-cycle grant pulse.
- `m_x`  out  1  drives machine `x`.
- `m_reset`  out  1  drives machine `RESET`.
- `m_f`  in  1  machine output F.
- `m_s`  in  3  machine state S.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle completion pulse.
- `done_id`  out  1  requester served (0/1), valid with `done`.
- `err`  out  1  high with `done` when the run was rejected (len = 0).
- `f_trace`  out  W  bit k = `m_f` sampled during step k; bits at index ≥ len are 0.
- `final_s`  out  3  `m_s` after the last step.

## Operation
- FSM states: IDLE, CLR, RUN, CAP, DONE.
- IDLE: `m_x` = 0, `m_reset` = 0.
  - If exactly one request is high, that requester wins.
  - If both are high, the requester not served last wins. `last_id` resets to 1, so `req0` wins the first tie.
  - On a win: latch pat/len/id and set `last_id` = id.
  - Next state is CLR, or DONE if len = 0.
- CLR: one cycle. `m_reset` = 1, `gnt<id>` = 1. Clear `f_trace` and the step counter.
- RUN: lasts len cycles. In step k, `m_x` = pat[k]. At the closing edge of step k, capture `f_trace[k]` ← `m_f`. After step len−1, go to CAP.
- CAP: `m_x` = 0. At the closing edge, capture `final_s` ← `m_s`.
- DONE: one cycle. `done` = 1, `done_id` = id, `err` = (len = 0). Next state is IDLE.
- len = 0 path: grant pulse fires in the DONE cycle. `err` = 1. `f_trace` = 0, `final_s` = 0. No `m_reset` pulse.
- `f_trace`, `final_s`, and `done_id` hold their values until the next grant.
- A requester that still holds `req` after its `done` is re-arbitrated in the following IDLE cycle. It wins only if the other requester is not asking.
- Requests arriving while `busy` are ignored until the FSM returns to IDLE. There is no queueing beyond the held `req` level.
- `m_reset` = (state == CLR) OR `RESET`. The machine is cleared whenever the sequencer is reset.

## Timing
- Reset values:
  - State = IDLE, `last_id` = 1.
  - `gnt0`/`gnt1`/`done`/`err`/`busy`/`m_x` = 0.
  - `f_trace` = 0, `final_s` = 0, `done_id` = 0.
  - `m_reset` = 1 while `RESET` is high.
- Cycle map for a legal run, with a request accepted in IDLE cycle t:
  - t+1: CLR (grant).
  - t+2 … t+1+len: RUN.
  - t+2+len: CAP.
  - t+3+len: DONE.
  - t+4+len: IDLE.
- Latency from winning request to `done` is len+3 cycles. Back-to-back runs are separated by one IDLE cycle.
- len = 0: DONE at t+1. Latency is 1 cycle.
- `RESET` asserted mid-run: at the next edge, go to IDLE with all outputs at reset values. No `done` is issued and the partial trace is discarded.
- `RESET` and `req` high together: reset wins and there is no grant.

## Test plan
- The bench machine stub behaves as follows: `m_reset` clears S to 0; otherwise S increments mod 8 each cycle; F = S[0].
- `req0`, pat0 = 8'h00, len0 = 5 → gnt0 at t+1, RUN for 5 cycles. At t+8: `done` = 1, `done_id` = 0, `f_trace` = 8'h0A, `final_s` = 5, `err` = 0.
- `req0` = `req1` = 1 together after reset → req0 served first. With both held, req1 is served next, then req0. Grants strictly alternate.
- pat1 = 8'hB5, len1 = 8 → `m_x` over the RUN cycles is 1,0,1,0,1,1,0,1. `final_s` = 0 (8 mod 8). `f_trace` = 8'hAA.
- len0 = 0 → gnt0 and `done` (with `err` = 1) in the cycle after the request. `m_reset` is never pulsed.
- `RESET` during RUN step 3 of a len = 6 run → next cycle IDLE, `busy` = 0, `f_trace` = 0, no `done`. A held `req` restarts the run from CLR.
- len0 = 12 with W = 8 → clamped to 8 steps. `done` arrives 11 cycles after the grant cycle's IDLE.
